// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: default entry layout, opcode_id constants
// and the immediate-operand decode used by the dispatch stage to drive in_use_imm.
package rs_pkg;

    localparam int RS_XLEN  = 32;
    localparam int RS_TAG_W = 4;
    localparam int RS_OP_W  = 6;

    // Entry layout at the default widths; the queue builds the same shape from its parameters.
    typedef struct packed {
        logic                busy;
        logic [RS_OP_W-1:0]  opcode;
        logic [RS_XLEN-1:0]  vj;
        logic [RS_XLEN-1:0]  vk;
        logic [RS_TAG_W-1:0] qj_tag;
        logic [RS_TAG_W-1:0] qk_tag;
        logic                rdy_j;
        logic                rdy_k;
        logic [RS_XLEN-1:0]  imm;
        logic [RS_TAG_W-1:0] rob;
    } rs_entry_t;

    localparam logic [RS_OP_W-1:0] OP_ADD   = 6'd0;
    localparam logic [RS_OP_W-1:0] OP_SUB   = 6'd1;
    localparam logic [RS_OP_W-1:0] OP_AND   = 6'd2;
    localparam logic [RS_OP_W-1:0] OP_OR    = 6'd3;
    localparam logic [RS_OP_W-1:0] OP_XOR   = 6'd4;
    localparam logic [RS_OP_W-1:0] OP_SLL   = 6'd5;
    localparam logic [RS_OP_W-1:0] OP_SRL   = 6'd6;
    localparam logic [RS_OP_W-1:0] OP_SLT   = 6'd7;
    localparam logic [RS_OP_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [RS_OP_W-1:0] OP_ANDI  = 6'd9;
    localparam logic [RS_OP_W-1:0] OP_ORI   = 6'd10;
    localparam logic [RS_OP_W-1:0] OP_XORI  = 6'd11;
    localparam logic [RS_OP_W-1:0] OP_SLTI  = 6'd12;
    localparam logic [RS_OP_W-1:0] OP_LUI   = 6'd13;
    localparam logic [RS_OP_W-1:0] OP_JAL   = 6'd14;
    localparam logic [RS_OP_W-1:0] OP_JALR  = 6'd15;
    localparam logic [RS_OP_W-1:0] OP_BEQ   = 6'd16;
    localparam logic [RS_OP_W-1:0] OP_BNE   = 6'd17;

    function automatic logic use_imm(input logic [RS_OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
            OP_LUI, OP_JAL, OP_JALR: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rs_cdb_match.sv
// Compares one waiting operand tag against every CDB channel and returns the
// captured value; on an illegal multi-channel match the lowest channel wins.
module rs_cdb_match #(
    parameter int N_CDB = 2,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic [TAG_W-1:0]       tag_i,
    input  logic [N_CDB-1:0]       cdb_valid_i,
    input  logic [N_CDB*TAG_W-1:0] cdb_tag_i,
    input  logic [N_CDB*XLEN-1:0]  cdb_val_i,
    output logic                   hit_o,
    output logic [XLEN-1:0]        val_o
);

    // Scanning downward lets the lowest matching channel overwrite the others.
    always_comb begin
        hit_o = 1'b0;
        val_o = '0;
        for (int c = N_CDB - 1; c >= 0; c--) begin
            if (cdb_valid_i[c] && (cdb_tag_i[c*TAG_W +: TAG_W] == tag_i)) begin
                hit_o = 1'b1;
                val_o = cdb_val_i[c*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station: buffers dispatched instructions, captures operands from the
// CDBs (including same-cycle bypass) and issues the lowest ready entry each cycle.
module rs_issue_queue
    import rs_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6,
    parameter int N_CDB = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              in_opcode,
    input  logic                         in_rs1_ready,
    input  logic                         in_rs2_ready,
    input  logic [XLEN-1:0]              in_rs1_val,
    input  logic [XLEN-1:0]              in_rs2_val,
    input  logic [TAG_W-1:0]             in_rs1_tag,
    input  logic [TAG_W-1:0]             in_rs2_tag,
    input  logic                         in_use_imm,
    input  logic [XLEN-1:0]              in_imm,
    input  logic [TAG_W-1:0]             in_rob,
    input  logic [N_CDB-1:0]             cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]       cdb_tag,
    input  logic [N_CDB*XLEN-1:0]        cdb_val,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OP_W-1:0]              out_opcode,
    output logic [XLEN-1:0]              out_vj,
    output logic [XLEN-1:0]              out_vk,
    output logic [XLEN-1:0]              out_imm,
    output logic [TAG_W-1:0]             out_rob,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  opcode;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic [TAG_W-1:0] qj_tag;
        logic [TAG_W-1:0] qk_tag;
        logic             rdy_j;
        logic             rdy_k;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] rob;
    } entry_t;

    entry_t            entries_q [DEPTH];
    entry_t            entries_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DEPTH-1:0]  busyVec, readyVec;
    logic [DEPTH-1:0]  wakeJHit, wakeKHit;
    logic [XLEN-1:0]   wakeJVal [DEPTH];
    logic [XLEN-1:0]   wakeKVal [DEPTH];
    logic              bypJHit, bypKHit;
    logic [XLEN-1:0]   bypJVal, bypKVal;
    logic [IDX_W-1:0]  freeIdx, selIdx;
    logic              full, anyReady, doDispatch, doIssue;
    entry_t            newEntry;

    function automatic logic [IDX_W-1:0] firstFree(input logic [DEPTH-1:0] busy);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] firstReady(input logic [DEPTH-1:0] ready);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        assign busyVec[g]  = entries_q[g].busy;
        assign readyVec[g] = entries_q[g].busy && entries_q[g].rdy_j && entries_q[g].rdy_k;

        rs_cdb_match #(.N_CDB(N_CDB), .XLEN(XLEN), .TAG_W(TAG_W)) u_match_j (
            .tag_i       (entries_q[g].qj_tag),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_val_i   (cdb_val),
            .hit_o       (wakeJHit[g]),
            .val_o       (wakeJVal[g])
        );

        rs_cdb_match #(.N_CDB(N_CDB), .XLEN(XLEN), .TAG_W(TAG_W)) u_match_k (
            .tag_i       (entries_q[g].qk_tag),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_val_i   (cdb_val),
            .hit_o       (wakeKHit[g]),
            .val_o       (wakeKVal[g])
        );
    end

    rs_cdb_match #(.N_CDB(N_CDB), .XLEN(XLEN), .TAG_W(TAG_W)) u_bypass_j (
        .tag_i       (in_rs1_tag),
        .cdb_valid_i (cdb_valid),
        .cdb_tag_i   (cdb_tag),
        .cdb_val_i   (cdb_val),
        .hit_o       (bypJHit),
        .val_o       (bypJVal)
    );

    rs_cdb_match #(.N_CDB(N_CDB), .XLEN(XLEN), .TAG_W(TAG_W)) u_bypass_k (
        .tag_i       (in_rs2_tag),
        .cdb_valid_i (cdb_valid),
        .cdb_tag_i   (cdb_tag),
        .cdb_val_i   (cdb_val),
        .hit_o       (bypKHit),
        .val_o       (bypKVal)
    );

    assign full       = &busyVec;
    assign anyReady   = |readyVec;
    assign freeIdx    = firstFree(busyVec);
    assign selIdx     = firstReady(readyVec);
    assign in_ready   = rdy && !full;
    assign out_valid  = rdy && anyReady;
    assign doDispatch = in_valid && in_ready;
    assign doIssue    = out_valid && out_ready;
    assign count      = count_q;

    assign out_opcode = out_valid ? entries_q[selIdx].opcode : '0;
    assign out_vj     = out_valid ? entries_q[selIdx].vj     : '0;
    assign out_vk     = out_valid ? entries_q[selIdx].vk     : '0;
    assign out_imm    = out_valid ? entries_q[selIdx].imm    : '0;
    assign out_rob    = out_valid ? entries_q[selIdx].rob    : '0;

    // An operand already resolved, or resolved by a CDB this very cycle, enters as ready.
    always_comb begin
        newEntry        = '0;
        newEntry.busy   = 1'b1;
        newEntry.opcode = in_opcode;
        newEntry.qj_tag = in_rs1_tag;
        newEntry.qk_tag = in_rs2_tag;
        newEntry.imm    = in_imm;
        newEntry.rob    = in_rob;
        if (in_rs1_ready) begin
            newEntry.rdy_j = 1'b1;
            newEntry.vj    = in_rs1_val;
        end else if (bypJHit) begin
            newEntry.rdy_j = 1'b1;
            newEntry.vj    = bypJVal;
        end
        if (in_use_imm) begin
            newEntry.rdy_k = 1'b1;
            newEntry.vk    = '0;
        end else if (in_rs2_ready) begin
            newEntry.rdy_k = 1'b1;
            newEntry.vk    = in_rs2_val;
        end else if (bypKHit) begin
            newEntry.rdy_k = 1'b1;
            newEntry.vk    = bypKVal;
        end
    end

    // Dispatch and issue never target the same slot: one is free, the other busy.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (rdy) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries_d[i].busy = 1'b0;
                end
                count_d = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries_q[i].busy && !entries_q[i].rdy_j && wakeJHit[i]) begin
                        entries_d[i].rdy_j = 1'b1;
                        entries_d[i].vj    = wakeJVal[i];
                    end
                    if (entries_q[i].busy && !entries_q[i].rdy_k && wakeKHit[i]) begin
                        entries_d[i].rdy_k = 1'b1;
                        entries_d[i].vk    = wakeKVal[i];
                    end
                end
                if (doIssue) begin
                    entries_d[selIdx].busy = 1'b0;
                end
                if (doDispatch) begin
                    entries_d[freeIdx] = newEntry;
                end
                if (doDispatch && !doIssue) begin
                    count_d = count_q + CNT_W'(1);
                end else if (doIssue && !doDispatch) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue with hand-computed expectations.
module tb_rs_issue_queue;
    import rs_pkg::*;

    localparam int DEPTH = 16;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int OP_W  = 6;
    localparam int N_CDB = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   rdy;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [OP_W-1:0]        in_opcode;
    logic                   in_rs1_ready, in_rs2_ready;
    logic [XLEN-1:0]        in_rs1_val, in_rs2_val;
    logic [TAG_W-1:0]       in_rs1_tag, in_rs2_tag;
    logic                   in_use_imm;
    logic [XLEN-1:0]        in_imm;
    logic [TAG_W-1:0]       in_rob;
    logic [N_CDB-1:0]       cdb_valid;
    logic [N_CDB*TAG_W-1:0] cdb_tag;
    logic [N_CDB*XLEN-1:0]  cdb_val;
    logic                   out_valid;
    logic                   out_ready;
    logic [OP_W-1:0]        out_opcode;
    logic [XLEN-1:0]        out_vj, out_vk, out_imm;
    logic [TAG_W-1:0]       out_rob;
    logic [CNT_W-1:0]       count;

    int errorCount = 0;
    int checkCount = 0;

    rs_issue_queue #(
        .DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .N_CDB(N_CDB)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rob(in_rob),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_vj(out_vj), .out_vk(out_vk), .out_imm(out_imm), .out_rob(out_rob),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance past the given number of rising edges and settle just after the last one.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_opcode    = '0;
        in_rs1_ready = 1'b0;
        in_rs2_ready = 1'b0;
        in_rs1_val   = '0;
        in_rs2_val   = '0;
        in_rs1_tag   = '0;
        in_rs2_tag   = '0;
        in_use_imm   = 1'b0;
        in_imm       = '0;
        in_rob       = '0;
        cdb_valid    = '0;
        cdb_tag      = '0;
        cdb_val      = '0;
    endtask

    task automatic setDispatch(input logic [OP_W-1:0] op,
                               input logic r1Rdy, input logic [XLEN-1:0] r1Val, input logic [TAG_W-1:0] r1Tag,
                               input logic r2Rdy, input logic [XLEN-1:0] r2Val, input logic [TAG_W-1:0] r2Tag,
                               input logic useImm, input logic [XLEN-1:0] imm, input logic [TAG_W-1:0] rob);
        in_valid     = 1'b1;
        in_opcode    = op;
        in_rs1_ready = r1Rdy;
        in_rs1_val   = r1Val;
        in_rs1_tag   = r1Tag;
        in_rs2_ready = r2Rdy;
        in_rs2_val   = r2Val;
        in_rs2_tag   = r2Tag;
        in_use_imm   = useImm;
        in_imm       = imm;
        in_rob       = rob;
    endtask

    task automatic setCdb(input int ch, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
        cdb_valid[ch]              = 1'b1;
        cdb_tag[ch*TAG_W +: TAG_W] = tag;
        cdb_val[ch*XLEN +: XLEN]   = val;
    endtask

    initial begin
        rst       = 1'b1;
        rdy       = 1'b1;
        out_ready = 1'b0;
        clearInputs();
        #12;
        rst = 1'b0;
        #1;
        checkOutput("resetCount", 64'(count), 64'd0);
        checkOutput("resetOutValid", 64'(out_valid), 64'd0);
        checkOutput("resetOutVj", 64'(out_vj), 64'd0);
        checkOutput("resetInReady", 64'(in_ready), 64'd1);

        // ADDI with immediate, issued the cycle after dispatch
        out_ready = 1'b1;
        setDispatch(OP_ADDI, 1'b1, 32'd5, 4'd0, 1'b0, 32'd0, 4'd0, 1'b1, 32'd7, 4'd3);
        checkOutput("addiNoCombPath", 64'(out_valid), 64'd0);
        applyStimulus(1);
        clearInputs();
        checkOutput("addiValid", 64'(out_valid), 64'd1);
        checkOutput("addiOpcode", 64'(out_opcode), 64'(OP_ADDI));
        checkOutput("addiVj", 64'(out_vj), 64'd5);
        checkOutput("addiVk", 64'(out_vk), 64'd0);
        checkOutput("addiImm", 64'(out_imm), 64'd7);
        checkOutput("addiRob", 64'(out_rob), 64'd3);
        checkOutput("addiCount1", 64'(count), 64'd1);
        applyStimulus(1);
        checkOutput("addiCount0", 64'(count), 64'd0);
        checkOutput("addiDone", 64'(out_valid), 64'd0);

        // ADD waiting on tag 2, woken by CDB channel 1
        setDispatch(OP_ADD, 1'b0, 32'd0, 4'd2, 1'b1, 32'd10, 4'd0, 1'b0, 32'd0, 4'd4);
        applyStimulus(1);
        clearInputs();
        checkOutput("addWaiting", 64'(out_valid), 64'd0);
        setCdb(1, 4'd2, 32'h1234);
        checkOutput("wakeNoCombPath", 64'(out_valid), 64'd0);
        applyStimulus(1);
        clearInputs();
        checkOutput("wakeValid", 64'(out_valid), 64'd1);
        checkOutput("wakeVj", 64'(out_vj), 64'h1234);
        checkOutput("wakeVk", 64'(out_vk), 64'd10);
        applyStimulus(1);
        checkOutput("wakeCount", 64'(count), 64'd0);

        // Both channels carry the same tag: channel 0 must win
        setDispatch(OP_SUB, 1'b0, 32'd0, 4'd4, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd5);
        applyStimulus(1);
        clearInputs();
        setCdb(0, 4'd4, 32'h11);
        setCdb(1, 4'd4, 32'h22);
        applyStimulus(1);
        clearInputs();
        checkOutput("dupCdbVj", 64'(out_vj), 64'h11);
        applyStimulus(1);

        // Same-cycle bypass on rs2
        setDispatch(OP_ADD, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd6);
        setCdb(0, 4'd6, 32'hAA);
        applyStimulus(1);
        clearInputs();
        checkOutput("bypassValid", 64'(out_valid), 64'd1);
        checkOutput("bypassVk", 64'(out_vk), 64'hAA);
        applyStimulus(1);
        checkOutput("bypassCount", 64'(count), 64'd0);

        // Fill every entry with issue blocked
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            setDispatch(OP_ADDI, 1'b1, XLEN'(100 + i), 4'd0, 1'b0, 32'd0, 4'd0, 1'b1, XLEN'(i), TAG_W'(i));
            applyStimulus(1);
        end
        checkOutput("fullCount", 64'(count), 64'(DEPTH));
        checkOutput("fullInReady", 64'(in_ready), 64'd0);
        checkOutput("fullHeadRob", 64'(out_rob), 64'd0);
        applyStimulus(1);
        clearInputs();
        checkOutput("fullRejects", 64'(count), 64'(DEPTH));
        out_ready = 1'b1;
        applyStimulus(1);
        out_ready = 1'b0;
        checkOutput("freedCount", 64'(count), 64'(DEPTH - 1));
        checkOutput("freedInReady", 64'(in_ready), 64'd1);
        checkOutput("freedNextRob", 64'(out_rob), 64'd1);
        checkOutput("freedNextVj", 64'(out_vj), 64'd101);
        out_ready = 1'b1;
        applyStimulus(DEPTH - 1);
        out_ready = 1'b0;
        checkOutput("drainCount", 64'(count), 64'd0);
        checkOutput("drainValid", 64'(out_valid), 64'd0);

        // Entries 3 and 5 ready, others waiting; hold then lower entry wakes
        for (int i = 0; i < 6; i++) begin
            if (i == 3 || i == 5)
                setDispatch(OP_ADDI, 1'b1, XLEN'(i), 4'd0, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, TAG_W'(i));
            else
                setDispatch(OP_ADDI, 1'b0, 32'd0, TAG_W'(9 + (i > 3 ? 3 : i)), 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, TAG_W'(i));
            applyStimulus(1);
        end
        clearInputs();
        for (int c = 0; c < 4; c++) begin
            checkOutput("holdValid", 64'(out_valid), 64'd1);
            checkOutput("holdRob", 64'(out_rob), 64'd3);
            applyStimulus(1);
        end
        setCdb(0, 4'd10, 32'h77);
        checkOutput("holdBeforeWake", 64'(out_rob), 64'd3);
        applyStimulus(1);
        clearInputs();
        checkOutput("switchRob", 64'(out_rob), 64'd1);
        checkOutput("switchVj", 64'(out_vj), 64'h77);
        checkOutput("sixBusy", 64'(count), 64'd6);

        // Flush beats a simultaneous dispatch and issue
        out_ready = 1'b1;
        flush = 1'b1;
        setDispatch(OP_ADDI, 1'b1, 32'd9, 4'd0, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, 4'd14);
        applyStimulus(1);
        clearInputs();
        checkOutput("flushCount", 64'(count), 64'd0);
        checkOutput("flushValid", 64'(out_valid), 64'd0);
        checkOutput("flushInReady", 64'(in_ready), 64'd1);
        applyStimulus(1);
        checkOutput("flushNotStored", 64'(out_valid), 64'd0);

        // rdy low freezes everything, including flush
        out_ready = 1'b0;
        setDispatch(OP_ADDI, 1'b1, 32'd8, 4'd0, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, 4'd7);
        applyStimulus(1);
        clearInputs();
        rdy       = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        setDispatch(OP_ADDI, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, 4'd8);
        #1;
        checkOutput("frozenInReady", 64'(in_ready), 64'd0);
        checkOutput("frozenOutValid", 64'(out_valid), 64'd0);
        applyStimulus(1);
        clearInputs();
        rdy       = 1'b1;
        out_ready = 1'b0;
        #1;
        checkOutput("frozenCount", 64'(count), 64'd1);
        checkOutput("frozenRob", 64'(out_rob), 64'd7);
        out_ready = 1'b1;
        applyStimulus(1);
        out_ready = 1'b0;
        checkOutput("frozenDrain", 64'(count), 64'd0);

        // Asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) begin
            setDispatch(OP_ADDI, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, TAG_W'(i));
            applyStimulus(1);
        end
        clearInputs();
        checkOutput("midFillCount", 64'(count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstCount", 64'(count), 64'd0);
        checkOutput("asyncRstValid", 64'(out_valid), 64'd0);
        #2;
        rst = 1'b0;
        applyStimulus(1);
        checkOutput("postRstInReady", 64'(in_ready), 64'd1);
        checkOutput("postRstCount", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
